// File: rtl/comparator.sv
// Masked unsigned comparator with a one-cycle registered result and
// saturating, clearable match statistics.
module comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Valid,
  input  logic [WIDTH-1:0] i_Data1,
  input  logic [WIDTH-1:0] i_Data2,
  input  logic [WIDTH-1:0] i_Mask,
  input  logic             i_Clear,
  output logic             o_Valid,
  output logic             o_Equal,
  output logic             o_Greater,
  output logic             o_Less,
  output logic [CNT_W-1:0] o_Match_Count,
  output logic             o_Match_Seen
);

  logic [WIDTH-1:0] masked_a;
  logic [WIDTH-1:0] masked_b;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cnt_full;

  assign masked_a = i_Data1 & i_Mask;
  assign masked_b = i_Data2 & i_Mask;
  assign cmp_eq   = (masked_a == masked_b);
  assign cmp_gt   = (masked_a >  masked_b);
  assign cmp_lt   = (masked_a <  masked_b);
  assign cnt_full = &o_Match_Count;

  // Result flags hold between valid compares; only o_Valid drops.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Valid   <= 1'b0;
      o_Equal   <= 1'b0;
      o_Greater <= 1'b0;
      o_Less    <= 1'b0;
    end else begin
      o_Valid <= i_Valid;
      if (i_Valid) begin
        o_Equal   <= cmp_eq;
        o_Greater <= cmp_gt;
        o_Less    <= cmp_lt;
      end
    end
  end

  // Clear takes priority over a coincident equal compare.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Match_Count <= '0;
      o_Match_Seen  <= 1'b0;
    end else if (i_Clear) begin
      o_Match_Count <= '0;
      o_Match_Seen  <= 1'b0;
    end else if (i_Valid && cmp_eq) begin
      o_Match_Seen <= 1'b1;
      if (!cnt_full) begin
        o_Match_Count <= o_Match_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Directed plus randomized checks of the comparator against a plain
// arithmetic model of the compare and match statistics.
module tb_comparator;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             valid;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] mask;
  logic             clear;
  logic             o_valid;
  logic             o_equal;
  logic             o_greater;
  logic             o_less;
  logic [CNT_W-1:0] o_count;
  logic             o_seen;

  int total = 0;
  int bad = 0;

  int m_valid, m_eq, m_gt, m_lt, m_cnt, m_seen;

  comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Valid      (valid),
    .i_Data1      (data1),
    .i_Data2      (data2),
    .i_Mask       (mask),
    .i_Clear      (clear),
    .o_Valid      (o_valid),
    .o_Equal      (o_equal),
    .o_Greater    (o_greater),
    .o_Less       (o_less),
    .o_Match_Count(o_count),
    .o_Match_Seen (o_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, o_valid}, m_valid);
    check({tag, ".equal"}, {31'd0, o_equal}, m_eq);
    check({tag, ".greater"}, {31'd0, o_greater}, m_gt);
    check({tag, ".less"}, {31'd0, o_less}, m_lt);
    check({tag, ".count"}, {28'd0, o_count}, m_cnt);
    check({tag, ".seen"}, {31'd0, o_seen}, m_seen);
    if (m_valid == 1)
      check({tag, ".onehot"}, 32'(o_equal) + 32'(o_greater) + 32'(o_less), 1);
  endtask

  task automatic model_reset();
    m_valid = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_cnt = 0; m_seen = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, then check outputs.
  task automatic step(input string tag, input int v, input int a, input int b,
                      input int m, input int c);
    int ma, mb;
    valid = v[0];
    data1 = a[WIDTH-1:0];
    data2 = b[WIDTH-1:0];
    mask  = m[WIDTH-1:0];
    clear = c[0];
    @(posedge clk);
    #1;
    m_valid = v;
    if (v != 0) begin
      ma = a & m;
      mb = b & m;
      m_eq = (ma == mb) ? 1 : 0;
      m_gt = (ma > mb) ? 1 : 0;
      m_lt = (ma < mb) ? 1 : 0;
      if (ma == mb) begin
        m_seen = 1;
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end
    if (c != 0) begin
      m_cnt = 0;
      m_seen = 0;
    end
    check_all(tag);
  endtask

  initial begin
    int a, b, m, v, c;
    rst_n = 1'b0;
    valid = 1'b1;
    data1 = 8'h55;
    data2 = 8'h55;
    mask  = 8'hFF;
    clear = 1'b0;
    model_reset();
    #2;
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_held_valid");
    valid = 1'b0;
    #2;
    rst_n = 1'b1;

    step("gt_ab_aa", 1, 'hAB, 'hAA, 'hFF, 0);
    step("eq_ab_ab", 1, 'hAB, 'hAB, 'hFF, 0);
    for (int i = 0; i < 3; i++) step("idle_hold", 0, 'h12, 'h99, 'hFF, 0);
    step("mask_f0_eq", 1, 'hAB, 'hA0, 'hF0, 0);
    step("mask_00_eq", 1, 'h12, 'h34, 'h00, 0);
    step("lt_12_34", 1, 'h12, 'h34, 'hFF, 0);
    step("idle_ignore_ops", 0, 'hAB, 'hAB, 'hFF, 0);

    step("clear_only", 0, 0, 0, 'hFF, 1);
    for (int i = 0; i < 16; i++) step("sat_run", 1, i, i, 'hFF, 0);
    check("sat_at_15", {28'd0, o_count}, 15);
    for (int i = 0; i < 3; i++) step("sat_hold", 1, 'h3C, 'h3C, 'hFF, 0);

    step("clear_vs_eq", 1, 'h5A, 'h5A, 'hFF, 1);
    step("eq_after_clear", 1, 'h77, 'h77, 'h0F, 0);
    step("gt_clear_same", 1, 'hF0, 'h0F, 'hFF, 1);

    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 15) == 0) ? 1 : 0;
      a = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: m = 'hFF;
        1: m = 'h00;
        default: m = $urandom_range(0, 255);
      endcase
      b = ($urandom_range(0, 2) == 0) ? a ^ ($urandom_range(0, 255) & ~m) : $urandom_range(0, 255);
      step("rand", v, a, b, m, c);
    end

    // Reset between sampling a compare and its register edge drops it.
    step("pre_rst_eq", 1, 'h11, 'h11, 'hFF, 0);
    valid = 1'b1;
    data1 = 8'hAB;
    data2 = 8'hAB;
    mask  = 8'hFF;
    clear = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst_async");
    @(posedge clk);
    #1;
    check_all("mid_rst_held");
    #2;
    rst_n = 1'b1;
    step("post_rst_eq", 1, 'hAB, 'hAB, 'hFF, 0);
    check("post_rst_count1", {28'd0, o_count}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 8 and set the compare operand width in bits.
REQ-003 Parameter CNT_W SHALL default to 16 and set the match counter width in bits.
REQ-004 Port i_Clk SHALL be an input, 1 bit wide: the system clock, with all state changing on its rising edge.
REQ-005 Port i_Rst_n SHALL be an input, 1 bit wide: the asynchronous active-low reset.
REQ-006 Port i_Valid SHALL be an input, 1 bit wide: marks the operands as valid for a compare in this cycle.
REQ-007 Port i_Data1 SHALL be an input, WIDTH bits wide: operand A.
REQ-008 Port i_Data2 SHALL be an input, WIDTH bits wide: operand B.
REQ-009 Port i_Mask SHALL be an input, WIDTH bits wide: per-bit compare enable, where 1 means the bit participates in the compare.
REQ-010 Port i_Clear SHALL be an input, 1 bit wide: synchronous clear of the match statistics.
REQ-011 Port o_Valid SHALL be an output, 1 bit wide: a one-cycle pulse marking that the result outputs are fresh.
REQ-012 Port o_Equal SHALL be an output, 1 bit wide: the masked operands are equal.
REQ-013 Port o_Greater SHALL be an output, 1 bit wide: masked A is greater than masked B, unsigned.
REQ-014 Port o_Less SHALL be an output, 1 bit wide: masked A is less than masked B, unsigned.
REQ-015 Port o_Match_Count SHALL be an output, CNT_W bits wide: the number of valid compares that gave equal, saturating.
REQ-016 Port o_Match_Seen SHALL be an output, 1 bit wide: a sticky flag, set on any valid equal compare.

Function
REQ-017 Masked operands SHALL be computed as MA = i_Data1 AND i_Mask and MB = i_Data2 AND i_Mask.
REQ-018 The compare results SHALL be: Equal = (MA == MB), Greater = (MA > MB), Less = (MA < MB), all as unsigned compares.
REQ-019 Exactly one of o_Equal, o_Greater and o_Less SHALL be 1 after any valid compare.
REQ-020 If i_Mask is all zeros, the block SHALL give o_Equal=1, o_Greater=0 and o_Less=0.
REQ-021 Latency SHALL be one cycle: operands sampled with i_Valid=1 on edge N SHALL produce results on the outputs after edge N, together with o_Valid=1 for exactly that cycle.
REQ-022 Back-to-back valid compares SHALL each produce a result on consecutive cycles, with no bubbles.
REQ-023 When i_Valid=0 at an edge, o_Valid SHALL go to 0 after that edge.
REQ-024 When i_Valid=0 at an edge, o_Equal, o_Greater and o_Less SHALL hold their previous values.
REQ-025 Operand values presented while i_Valid=0 SHALL have no effect on any output.
REQ-026 On each valid compare that gives equal, o_Match_Count SHALL increment by 1 in the same cycle that the result is registered.
REQ-027 o_Match_Count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 On each valid compare that gives equal, o_Match_Seen SHALL be set to 1 and SHALL stay 1 until it is cleared.
REQ-029 When i_Clear=1 at an edge, o_Match_Count and o_Match_Seen SHALL be set to 0 after that edge.
REQ-030 If i_Clear=1 and a valid equal compare occur at the same edge, the clear SHALL win for o_Match_Count and o_Match_Seen.
REQ-031 If i_Clear=1 and a valid compare occur at the same edge, o_Valid, o_Equal, o_Greater and o_Less SHALL still update normally.
REQ-032 i_Clear SHALL have no effect on o_Valid, o_Equal, o_Greater or o_Less.

Reset
REQ-033 When i_Rst_n=0, the block SHALL immediately, without waiting for a clock edge, drive o_Valid, o_Equal, o_Greater, o_Less, o_Match_Count and o_Match_Seen to 0.
REQ-034 All outputs SHALL remain at 0 for as long as i_Rst_n=0, regardless of i_Valid or i_Clear.
REQ-035 The first edge after i_Rst_n goes high with i_Valid=1 SHALL perform a normal compare.
REQ-036 Asserting reset in the cycle between sampling a compare and registering its result SHALL discard that result: o_Valid SHALL stay 0 and o_Match_Count SHALL stay 0.

Verification
REQ-037 The bench SHALL check: mask=FF, A=AB, B=AA, valid -> next cycle o_Valid=1, o_Equal=0, o_Greater=1, o_Less=0, o_Match_Count=0.
REQ-038 The bench SHALL check: mask=FF, A=AB, B=AB, valid -> next cycle o_Equal=1, o_Greater=0, o_Less=0, o_Match_Count=1, o_Match_Seen=1; then i_Valid=0 for 3 cycles -> o_Valid=0 and the flags hold.
REQ-039 The bench SHALL check: mask=F0, A=AB, B=A0 -> o_Equal=1; mask=00, A=12, B=34 -> o_Equal=1; mask=FF, A=12, B=34 -> o_Less=1.
REQ-040 The bench SHALL check, with CNT_W=4: 16 consecutive valid equal compares -> o_Match_Count=15 and it stays at 15.
REQ-041 The bench SHALL check: i_Clear=1 at the same edge as a valid equal compare -> o_Match_Count=0, o_Match_Seen=0, o_Valid=1, o_Equal=1.
REQ-042 The bench SHALL check: i_Rst_n driven low mid-stream, between clock edges -> all outputs 0 at once; after release, A=AB, B=AB, valid -> o_Match_Count=1.
